ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ============================================================================
// ex_stage -- execute stage of a 5-stage in-order pipeline.
//
// Purpose
//   Selects forwarded operands, runs the single-cycle ALU and drives the
//   EX/MEM pipeline register. An optional multi-cycle multiply/divide engine
//   with HI/LO registers is built when EX_STAGE_MULDIV_EN is defined. Without
//   that macro, opcodes 12-17 retire as bubbles with a zero result, and
//   ex_stall is tied to 0.
//
// Configuration macro
//   EX_STAGE_MULDIV_EN : build the MULT/MULTU/DIV/DIVU engine and MFHI/MFLO.
//
// Ports
//   clk                      in  1   sole clock, rising edge
//   rst_n                    in  1   asynchronous active-low reset
//   EX_valid                 in  1   ID/EX holds a real instruction
//   EX_RegWrite/EX_MemRead/
//   EX_MemWrite/EX_ALUSrc    in  1   ID/EX control bits
//   EX_alu_op                in  5   ALU / muldiv operation code
//   EX_rs_data/EX_rt_data    in  32  register file operands
//   EX_imm                   in  32  sign-extended immediate (shamt in [10:6])
//   EX_write_register        in  5   destination register
//   Forward_in1_sel/_in2_sel in  2   0/3 register, 1 EX/MEM result, 2 WB data
//   WB_write_data_register   in  32  write-back forward source
//   MEM_*                    out     EX/MEM pipeline register contents
//   ex_stall                 out 1   combinational; holds IF/ID/EX upstream
// ============================================================================
module ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EX_valid,
    input  logic        EX_RegWrite,
    input  logic        EX_MemRead,
    input  logic        EX_MemWrite,
    input  logic        EX_ALUSrc,
    input  logic [4:0]  EX_alu_op,
    input  logic [31:0] EX_rs_data,
    input  logic [31:0] EX_rt_data,
    input  logic [31:0] EX_imm,
    input  logic [4:0]  EX_write_register,
    input  logic [1:0]  Forward_in1_sel,
    input  logic [1:0]  Forward_in2_sel,
    input  logic [31:0] WB_write_data_register,
    output logic        MEM_valid,
    output logic        MEM_RegWrite,
    output logic        MEM_MemRead,
    output logic        MEM_MemWrite,
    output logic [31:0] MEM_ALU_result,
    output logic [31:0] MEM_write_data,
    output logic [4:0]  MEM_write_register,
    output logic        ex_stall
);

    // ------------------------------------------------------------------
    // Operation codes
    // ------------------------------------------------------------------
    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_NOR   = 5'd5;
    localparam logic [4:0] OP_SLT   = 5'd6;
    localparam logic [4:0] OP_SLTU  = 5'd7;
    localparam logic [4:0] OP_SLL   = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9;
    localparam logic [4:0] OP_SRA   = 5'd10;
    localparam logic [4:0] OP_LUI   = 5'd11;
    localparam logic [4:0] OP_MULT  = 5'd12;
    localparam logic [4:0] OP_DIVU  = 5'd15;
    localparam logic [4:0] OP_MFLO  = 5'd17;
`ifdef EX_STAGE_MULDIV_EN
    localparam logic [4:0] OP_MFHI  = 5'd16;
`endif

    // Forwarding mux: codes 0 and 3 both select the register file value.
    function automatic logic [31:0] fwd_mux(
        input logic [1:0]  sel,
        input logic [31:0] reg_data,
        input logic [31:0] mem_data,
        input logic [31:0] wb_data
    );
        logic [31:0] res;
        case (sel)
            2'd1:    res = mem_data;
            2'd2:    res = wb_data;
            default: res = reg_data;
        endcase
        return res;
    endfunction

    // Two's-complement magnitude of a 32-bit signed value (0x80000000 stays as-is).
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    // ------------------------------------------------------------------
    // EX/MEM register state
    // ------------------------------------------------------------------
    logic        mem_valid_q,    mem_valid_d;
    logic        mem_regwrite_q, mem_regwrite_d;
    logic        mem_memread_q,  mem_memread_d;
    logic        mem_memwrite_q, mem_memwrite_d;
    logic [31:0] mem_result_q,   mem_result_d;
    logic [31:0] mem_wdata_q,    mem_wdata_d;
    logic [4:0]  mem_wreg_q,     mem_wreg_d;

    // Datapath signals
    logic [31:0] op_a_s;
    logic [31:0] fwd_rt_s;
    logic [31:0] op_b_s;
    logic [4:0]  shamt_s;
    logic [31:0] alu_result_s;
    logic        no_pass_op_s;   // opcode never carries its controls into MEM
    logic        stall_s;

    // Operand selection with forwarding; the store data always follows rt.
    always_comb begin
        op_a_s   = fwd_mux(Forward_in1_sel, EX_rs_data, mem_result_q, WB_write_data_register);
        fwd_rt_s = fwd_mux(Forward_in2_sel, EX_rt_data, mem_result_q, WB_write_data_register);
        if (EX_ALUSrc) begin
            op_b_s = EX_imm;
        end else begin
            op_b_s = fwd_rt_s;
        end
        shamt_s = EX_imm[10:6];
    end

`ifdef EX_STAGE_MULDIV_EN
    // ------------------------------------------------------------------
    // Multiply / divide engine. Operands are captured on the first edge
    // and the result is committed to HI/LO when the 32-cycle window closes,
    // so later forwarding changes cannot disturb it.
    // ------------------------------------------------------------------
    logic        busy_q,  busy_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] md_a_q,  md_a_d;
    logic [31:0] md_b_q,  md_b_d;
    logic [1:0]  md_op_q, md_op_d;   // 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;

    logic        is_muldiv_s;
    logic        md_last_s;
    logic [63:0] md_prod_s;
    logic [31:0] md_abs_a_s;
    logic [31:0] md_abs_b_s;
    logic [31:0] md_q_mag_s;
    logic [31:0] md_r_mag_s;
    logic [31:0] md_hi_s;
    logic [31:0] md_lo_s;

    assign is_muldiv_s  = (EX_alu_op >= OP_MULT) && (EX_alu_op <= OP_DIVU);
    assign md_last_s    = busy_q && (count_q == 5'd31);
    assign no_pass_op_s = is_muldiv_s;
    // Stall is forced low while reset is asserted.
    assign stall_s      = rst_n & EX_valid & is_muldiv_s & ~md_last_s;

    // Result of the latched muldiv operation, consumed only on the release edge.
    always_comb begin
        md_prod_s  = 64'd0;
        md_abs_a_s = 32'd0;
        md_abs_b_s = 32'd1;
        md_q_mag_s = 32'd0;
        md_r_mag_s = 32'd0;
        md_hi_s    = hi_q;
        md_lo_s    = lo_q;
        case (md_op_q)
            2'd0: begin
                // Sign-extending both factors to 64 bits makes the low 64
                // bits of an unsigned product equal the signed product.
                md_prod_s = {{32{md_a_q[31]}}, md_a_q} * {{32{md_b_q[31]}}, md_b_q};
                md_hi_s   = md_prod_s[63:32];
                md_lo_s   = md_prod_s[31:0];
            end
            2'd1: begin
                md_prod_s = {32'd0, md_a_q} * {32'd0, md_b_q};
                md_hi_s   = md_prod_s[63:32];
                md_lo_s   = md_prod_s[31:0];
            end
            2'd2: begin
                if (md_b_q == 32'd0) begin
                    md_lo_s = 32'hFFFF_FFFF;
                    md_hi_s = md_a_q;
                end else begin
                    // Divide magnitudes, then restore signs: the quotient
                    // truncates toward zero, the remainder follows the dividend.
                    md_abs_a_s = abs32(md_a_q);
                    md_abs_b_s = abs32(md_b_q);
                    md_q_mag_s = md_abs_a_s / md_abs_b_s;
                    md_r_mag_s = md_abs_a_s % md_abs_b_s;
                    if (md_a_q[31] ^ md_b_q[31]) begin
                        md_lo_s = ~md_q_mag_s + 32'd1;
                    end else begin
                        md_lo_s = md_q_mag_s;
                    end
                    if (md_a_q[31]) begin
                        md_hi_s = ~md_r_mag_s + 32'd1;
                    end else begin
                        md_hi_s = md_r_mag_s;
                    end
                end
            end
            default: begin
                if (md_b_q == 32'd0) begin
                    md_lo_s = 32'hFFFF_FFFF;
                    md_hi_s = md_a_q;
                end else begin
                    md_abs_b_s = md_b_q;
                    md_lo_s    = md_a_q / md_abs_b_s;
                    md_hi_s    = md_a_q % md_abs_b_s;
                end
            end
        endcase
    end

    // Engine sequencing: idle start, 32-cycle count, commit on the final cycle.
    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        md_a_d  = md_a_q;
        md_b_d  = md_b_q;
        md_op_d = md_op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (busy_q) begin
            if (count_q == 5'd31) begin
                busy_d  = 1'b0;
                count_d = 5'd0;
                hi_d    = md_hi_s;
                lo_d    = md_lo_s;
            end else begin
                count_d = count_q + 5'd1;
            end
        end else if (EX_valid && is_muldiv_s) begin
            busy_d  = 1'b1;
            count_d = 5'd0;
            md_a_d  = op_a_s;
            md_b_d  = op_b_s;
            md_op_d = EX_alu_op[1:0];
        end else begin
            busy_d  = 1'b0;
        end
    end

    // Engine state and HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            count_q <= 5'd0;
            md_a_q  <= 32'd0;
            md_b_q  <= 32'd0;
            md_op_q <= 2'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            md_a_q  <= md_a_d;
            md_b_q  <= md_b_d;
            md_op_q <= md_op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
`else
    // Without the engine, opcodes 12-17 retire as zero-result bubbles.
    assign no_pass_op_s = (EX_alu_op >= OP_MULT) && (EX_alu_op <= OP_MFLO);
    assign stall_s      = 1'b0;
`endif

    assign ex_stall = stall_s;

    // Single-cycle ALU.
    always_comb begin
        alu_result_s = 32'd0;
        case (EX_alu_op)
            OP_ADD:  alu_result_s = op_a_s + op_b_s;
            OP_SUB:  alu_result_s = op_a_s - op_b_s;
            OP_AND:  alu_result_s = op_a_s & op_b_s;
            OP_OR:   alu_result_s = op_a_s | op_b_s;
            OP_XOR:  alu_result_s = op_a_s ^ op_b_s;
            OP_NOR:  alu_result_s = ~(op_a_s | op_b_s);
            OP_SLT:  alu_result_s = {31'd0, ($signed(op_a_s) < $signed(op_b_s))};
            OP_SLTU: alu_result_s = {31'd0, (op_a_s < op_b_s)};
            OP_SLL:  alu_result_s = op_b_s << shamt_s;
            OP_SRL:  alu_result_s = op_b_s >> shamt_s;
            OP_SRA:  alu_result_s = $signed(op_b_s) >>> shamt_s;
            OP_LUI:  alu_result_s = {op_b_s[15:0], 16'h0000};
`ifdef EX_STAGE_MULDIV_EN
            OP_MFHI: alu_result_s = hi_q;
            OP_MFLO: alu_result_s = lo_q;
`endif
            default: alu_result_s = 32'd0;
        endcase
    end

    // EX/MEM next state: controls pass only for a valid, unstalled, non-muldiv op.
    always_comb begin
        mem_valid_d    = 1'b0;
        mem_regwrite_d = 1'b0;
        mem_memread_d  = 1'b0;
        mem_memwrite_d = 1'b0;
        mem_result_d   = alu_result_s;
        mem_wdata_d    = fwd_rt_s;
        mem_wreg_d     = EX_write_register;
        if (EX_valid && !stall_s && !no_pass_op_s) begin
            mem_valid_d    = 1'b1;
            mem_regwrite_d = EX_RegWrite;
            mem_memread_d  = EX_MemRead;
            mem_memwrite_d = EX_MemWrite;
        end else begin
            mem_valid_d    = 1'b0;
        end
    end

    // EX/MEM pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_q    <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_memread_q  <= 1'b0;
            mem_memwrite_q <= 1'b0;
            mem_result_q   <= 32'd0;
            mem_wdata_q    <= 32'd0;
            mem_wreg_q     <= 5'd0;
        end else begin
            mem_valid_q    <= mem_valid_d;
            mem_regwrite_q <= mem_regwrite_d;
            mem_memread_q  <= mem_memread_d;
            mem_memwrite_q <= mem_memwrite_d;
            mem_result_q   <= mem_result_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wreg_q     <= mem_wreg_d;
        end
    end

    assign MEM_valid          = mem_valid_q;
    assign MEM_RegWrite       = mem_regwrite_q;
    assign MEM_MemRead        = mem_memread_q;
    assign MEM_MemWrite       = mem_memwrite_q;
    assign MEM_ALU_result     = mem_result_q;
    assign MEM_write_data     = mem_wdata_q;
    assign MEM_write_register = mem_wreg_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: hand-computed vectors, immediate assertions.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        EX_valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_ALUSrc;
    logic [4:0]  EX_alu_op;
    logic [31:0] EX_rs_data, EX_rt_data, EX_imm;
    logic [4:0]  EX_write_register;
    logic [1:0]  Forward_in1_sel, Forward_in2_sel;
    logic [31:0] WB_write_data_register;
    logic        MEM_valid, MEM_RegWrite, MEM_MemRead, MEM_MemWrite;
    logic [31:0] MEM_ALU_result, MEM_write_data;
    logic [4:0]  MEM_write_register;
    logic        ex_stall;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .EX_valid(EX_valid), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .EX_MemWrite(EX_MemWrite), .EX_ALUSrc(EX_ALUSrc), .EX_alu_op(EX_alu_op),
        .EX_rs_data(EX_rs_data), .EX_rt_data(EX_rt_data), .EX_imm(EX_imm),
        .EX_write_register(EX_write_register),
        .Forward_in1_sel(Forward_in1_sel), .Forward_in2_sel(Forward_in2_sel),
        .WB_write_data_register(WB_write_data_register),
        .MEM_valid(MEM_valid), .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead),
        .MEM_MemWrite(MEM_MemWrite), .MEM_ALU_result(MEM_ALU_result),
        .MEM_write_data(MEM_write_data), .MEM_write_register(MEM_write_register),
        .ex_stall(ex_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic alusrc,
                         input logic [1:0] f1, input logic [1:0] f2);
        EX_valid        = 1'b1;
        EX_alu_op       = op;
        EX_rs_data      = rs;
        EX_rt_data      = rt;
        EX_imm          = imm;
        EX_ALUSrc       = alusrc;
        Forward_in1_sel = f1;
        Forward_in2_sel = f2;
    endtask

    // Single-cycle op: issue, clock once, check the registered result.
    task automatic alu(input string tag, input logic [4:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] imm, input logic alusrc,
                       input logic [31:0] exp);
        issue(op, rs, rt, imm, alusrc, 2'd0, 2'd0);
        step();
        chk(tag, MEM_ALU_result, exp);
    endtask

`ifdef EX_STAGE_MULDIV_EN
    // Count stall cycles of a muldiv op already in EX, then clock the release edge.
    // rs is scrambled after the start edge to show operands are latched.
    task automatic wait_md(input string tag);
        int n;
        n = 0;
        while (ex_stall === 1'b1 && n < 100) begin
            step();
            n++;
            if (n == 1) EX_rs_data = 32'hDEAD_BEEF;
        end
        chk({tag, " stall cycles"}, n, 32'd32);
        step();
        chk({tag, " release bubble"}, {31'd0, MEM_valid}, 32'd0);
    endtask

    task automatic run_md(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        issue(op, a, b, 32'd0, 1'b0, 2'd0, 2'd0);
        #1;
        wait_md(tag);
        alu({tag, " mfhi"}, 5'd16, 32'd0, 32'd0, 32'd0, 1'b0, exp_hi);
        alu({tag, " mflo"}, 5'd17, 32'd0, 32'd0, 32'd0, 1'b0, exp_lo);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        EX_valid = 1'b1; EX_RegWrite = 1'b1; EX_MemRead = 1'b0; EX_MemWrite = 1'b0;
        EX_ALUSrc = 1'b0; EX_alu_op = 5'd12; EX_rs_data = 32'd5; EX_rt_data = 32'd7;
        EX_imm = 32'd0; EX_write_register = 5'd17;
        Forward_in1_sel = 2'd0; Forward_in2_sel = 2'd0; WB_write_data_register = 32'd9;

        // Reset state with a MULT presented: no stall, EX/MEM cleared.
        #12;
        chk("reset stall", {31'd0, ex_stall}, 32'd0);
        chk("reset valid", {31'd0, MEM_valid}, 32'd0);
        chk("reset result", MEM_ALU_result, 32'd0);
        chk("reset regwrite", {31'd0, MEM_RegWrite}, 32'd0);
        EX_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // Preload MEM_ALU_result = 5 for the forwarding checks.
        alu("add preload", 5'd0, 32'd3, 32'd0, 32'd2, 1'b1, 32'd5);
        chk("add valid", {31'd0, MEM_valid}, 32'd1);
        chk("add regwrite", {31'd0, MEM_RegWrite}, 32'd1);
        chk("write register", {27'd0, MEM_write_register}, 32'd17);

        // Forwarding on input 1.
        issue(5'd0, 32'd1, 32'd0, 32'd2, 1'b1, 2'd1, 2'd0); step();
        chk("fwd1 mem", MEM_ALU_result, 32'd7);
        issue(5'd0, 32'd1, 32'd0, 32'd2, 1'b1, 2'd2, 2'd0); step();
        chk("fwd1 wb", MEM_ALU_result, 32'd11);
        issue(5'd0, 32'd1, 32'd0, 32'd2, 1'b1, 2'd3, 2'd0); step();
        chk("fwd1 reg3", MEM_ALU_result, 32'd3);

        // Forwarding on input 2: store data and ALU operand both follow rt.
        issue(5'd3, 32'd0, 32'h55, 32'd0, 1'b0, 2'd0, 2'd2); step();
        chk("fwd2 wb result", MEM_ALU_result, 32'd9);
        chk("fwd2 wb wdata", MEM_write_data, 32'd9);
        issue(5'd3, 32'd0, 32'h55, 32'd0, 1'b1, 2'd0, 2'd1); step();
        chk("fwd2 mem wdata", MEM_write_data, 32'd9);
        chk("alusrc imm", MEM_ALU_result, 32'd0);

        // ALU operations.
        alu("sub wrap", 5'd1, 32'd0, 32'd1, 32'd0, 1'b0, 32'hFFFF_FFFF);
        alu("and", 5'd2, 32'hF0F0_1234, 32'h0FF0_00FF, 32'd0, 1'b0, 32'h00F0_0034);
        alu("or",  5'd3, 32'hF0F0_1234, 32'h0FF0_00FF, 32'd0, 1'b0, 32'hFFF0_12FF);
        alu("xor", 5'd4, 32'hF0F0_1234, 32'h0FF0_00FF, 32'd0, 1'b0, 32'hFF00_12CB);
        alu("nor", 5'd5, 32'hF0F0_1234, 32'h0FF0_00FF, 32'd0, 1'b0, 32'h000F_ED00);
        alu("slt",  5'd6, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 32'd1);
        alu("sltu", 5'd7, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 32'd0);
        alu("sll", 5'd8,  32'd0, 32'd1,          32'h0000_07C0, 1'b0, 32'h8000_0000);
        alu("srl", 5'd9,  32'd0, 32'h8000_0000,  32'h0000_0100, 1'b0, 32'h0800_0000);
        alu("sra", 5'd10, 32'd0, 32'h8000_0000,  32'h0000_0100, 1'b0, 32'hF800_0000);
        alu("lui", 5'd11, 32'd0, 32'd0,          32'h0000_1234, 1'b1, 32'h1234_0000);
        alu("op20 zero", 5'd20, 32'd7, 32'd7, 32'd0, 1'b0, 32'd0);
        chk("op20 valid", {31'd0, MEM_valid}, 32'd1);

        // Memory controls pass through for a valid op.
        EX_MemRead = 1'b1; EX_MemWrite = 1'b1;
        alu("mem ctl add", 5'd0, 32'd4, 32'd4, 32'd0, 1'b0, 32'd8);
        chk("memread pass", {31'd0, MEM_MemRead}, 32'd1);
        chk("memwrite pass", {31'd0, MEM_MemWrite}, 32'd1);

        // EX_valid = 0 loads a bubble.
        EX_valid = 1'b0; step();
        chk("bubble valid", {31'd0, MEM_valid}, 32'd0);
        chk("bubble regwrite", {31'd0, MEM_RegWrite}, 32'd0);
        chk("bubble memwrite", {31'd0, MEM_MemWrite}, 32'd0);
        EX_MemRead = 1'b0; EX_MemWrite = 1'b0;

        // Asynchronous reset mid-run clears EX/MEM without a clock edge.
        alu("pre reset add", 5'd0, 32'd20, 32'd1, 32'd0, 1'b0, 32'd21);
        rst_n = 1'b0;
        #1;
        chk("async rst valid", {31'd0, MEM_valid}, 32'd0);
        chk("async rst result", MEM_ALU_result, 32'd0);
        EX_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;

`ifdef EX_STAGE_MULDIV_EN
        run_md("mult", 5'd12, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_md("multu", 5'd13, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE);
        run_md("div", 5'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu by 0", 5'd15, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);

        // Reset at count = 10 aborts the MULT and clears HI/LO.
        issue(5'd12, 32'd5, 32'd7, 32'd0, 1'b0, 2'd0, 2'd0);
        #1;
        for (int i = 0; i < 11; i++) step();
        rst_n = 1'b0;
        #1;
        chk("mid rst stall", {31'd0, ex_stall}, 32'd0);
        chk("mid rst valid", {31'd0, MEM_valid}, 32'd0);
        issue(5'd16, 32'd0, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0);
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("rst hi cleared", MEM_ALU_result, 32'd0);
        alu("rst lo cleared", 5'd17, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);

        // Same abort, but the MULT stays in EX and restarts fresh.
        issue(5'd12, 32'd5, 32'd7, 32'd0, 1'b0, 2'd0, 2'd0);
        #1;
        for (int i = 0; i < 11; i++) step();
        rst_n = 1'b0;
        #1;
        chk("mid rst2 stall", {31'd0, ex_stall}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        wait_md("restart mult");
        alu("restart mflo", 5'd17, 32'd0, 32'd0, 32'd0, 1'b0, 32'd35);
`else
        // Without the engine MULT is a zero-result bubble and never stalls.
        issue(5'd12, 32'd5, 32'd7, 32'd0, 1'b0, 2'd0, 2'd0);
        #1;
        chk("mult no stall", {31'd0, ex_stall}, 32'd0);
        step();
        chk("mult bubble", {31'd0, MEM_valid}, 32'd0);
        chk("mult result", MEM_ALU_result, 32'd0);
        issue(5'd16, 32'd5, 32'd7, 32'd0, 1'b0, 2'd0, 2'd0);
        step();
        chk("mfhi bubble", {31'd0, MEM_valid}, 32'd0);
        chk("mfhi regwrite", {31'd0, MEM_RegWrite}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
